uart_fifo_bridge: RTL and testbench
===================================

// Module: uart_fifo_bridge
// PURPOSE
//  CPU-side buffering front end for the uart peripheral.
//  - Holds bytes the CPU writes in a TX FIFO and drains them into the uart write/tx_ready handshake.
//  - Collects every uart rx_new byte into an RX FIFO, acknowledging with read.
//  - Exposes DATA/STATUS/CTRL registers and a level irq on the 16-bit peripheral bus.
// PARAMETERS
//  DEPTH_LOG2  4  log2 of entries per FIFO (16 bytes each)
// PORTS
//  clk            in   1   system clock (same clock as uart.clk)
//  rst_n          in   1   asynchronous active-low reset
//  cpu_addr       in   2   register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//  cpu_wdata      in   16  write data
//  cpu_we         in   1   one-cycle write strobe
//  cpu_re         in   1   one-cycle read strobe
//  cpu_rdata      out  16  registered read data, valid the cycle after cpu_re
//  irq            out  1   level interrupt
//  uart_tx_data   out  8   byte to uart.tx_data_in
//  uart_write     out  1   to uart.write (uart acts on the rising edge)
//  uart_tx_ready  in   1   from uart.tx_ready
//  uart_rx_data   in   8   from uart.rx_data_out
//  uart_rx_new    in   1   from uart.rx_new
//  uart_read      out  1   to uart.read (uart acts on the rising edge)
// BEHAVIOUR
//  Reset values
//  - cpu_rdata=0, irq=0, uart_tx_data=0, uart_write=0, uart_read=0.
//  - Both FIFOs empty. CTRL=0. Sticky flags=0. Both FSMs in IDLE.
//  Register map
//  - DATA write: push cpu_wdata[7:0] to TX. If TX is full, drop the byte and set tx_drop.
//  - DATA read: pop RX and return {8'h00,byte}. If RX is empty, return 16'h0000 with no pop.
//  - STATUS read: {rx_count[7:0], 1'b0, tx_drop, rx_ovr, tx_full, tx_empty, rx_full, rx_empty, uart_tx_ready}.
//    rx_count is zero-extended from DEPTH_LOG2+1 bits.
//  - STATUS write: W1C on bit5 (rx_ovr) and bit6 (tx_drop). All other bits are ignored.
//  - CTRL: bit0 rx_ie, bit1 tx_ie. Bit2 flush is write-only and self-clearing; it empties both FIFOs next cycle.
//    CTRL read returns {14'b0, tx_ie, rx_ie}.
//  - Address 3 reads 0; writes are ignored.
//  - irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty), registered with 1-cycle latency.
//  TX FSM
//  - IDLE: when !tx_empty and uart_tx_ready, load uart_tx_data from the TX head, pop, go to STROBE.
//  - STROBE: uart_write=1 for exactly one cycle, then go to WAIT_LO.
//  - WAIT_LO: uart_write=0; wait for uart_tx_ready==0, then go to WAIT_HI.
//  - WAIT_HI: wait for uart_tx_ready==1, then go to IDLE.
//  - Result: at least one low cycle of uart_write between bytes. uart_tx_data is held stable from IDLE exit until the next load.
//  RX FSM
//  - IDLE: when uart_rx_new==1, push uart_rx_data. If RX is full, drop the byte and set rx_ovr. Then go to ACK.
//  - ACK: uart_read=1 for one cycle, then go to WAIT_CLR.
//  - WAIT_CLR: uart_read=0; wait for uart_rx_new==0, then go to IDLE.
//  - Each received byte is pushed exactly once.
//  Boundaries
//  - Same-cycle CPU pop and RX FSM push: both happen; count is unchanged. This also holds when the FIFO is full (pop frees the slot first).
//  - Same-cycle DATA write and TX FSM pop: both happen, including when TX is full.
//  - Flush coinciding with a push or pop: flush wins; the FIFO ends empty.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count is DEPTH_LOG2+1 bits.
//  - Reset mid-byte: the uart has no reset and finishes its frame. The TX FSM restarts in IDLE and waits for uart_tx_ready==1.
//  - rx_new high at reset release: the byte is captured normally.
// STRUCTURE
//  - Shared package uart_pkg: register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2), STATUS/CTRL bit indices, FSM state encodings.
//  - Sub-module uart_sync_fifo (WIDTH=8, DEPTH_LOG2), instantiated twice.
//    - Ports: push, pop, din, dout (show-ahead head), empty, full, count, flush.
//  - Top level holds the register decode, both FSMs, sticky flags and irq.
// TESTING
//  1. Reset, write DATA 0x41,0x42,0x43 with a uart model.
//     -> Three rising edges on uart_write, in order, each after tx_ready returns high. tx_empty=1 at the end.
//  2. Write 17 bytes with uart_tx_ready held 0.
//     -> STATUS tx_full=1, tx_drop=1, 16 bytes sent after ready.
//     -> W1C 0x0040 clears tx_drop.
//  3. Model delivers 0x55 then 0xAA via rx_new.
//     -> One uart_read pulse each. STATUS rx_count=2. DATA reads give 0x0055, 0x00AA, then 0x0000.
//  4. Deliver 17 bytes without CPU reads.
//     -> rx_full=1, rx_ovr=1. The first 16 bytes are kept and read back in order.
//  5. CTRL=0x0003 with RX empty and TX empty.
//     -> irq=1 (tx). Disable tx_ie -> irq=0. Receive a byte -> irq=1. Read DATA -> irq=0 two cycles later.
//  6. Assert rst_n=0 during STROBE.
//     -> All outputs 0 asynchronously. After release, no stray write edge until the CPU writes again.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart FIFO bridge: register offsets, register bit
// positions and FSM state encodings.
package uart_pkg;

    // Register offsets on the 16-bit peripheral bus
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int unsigned ST_TX_READY     = 0;
    localparam int unsigned ST_RX_EMPTY     = 1;
    localparam int unsigned ST_RX_FULL      = 2;
    localparam int unsigned ST_TX_EMPTY     = 3;
    localparam int unsigned ST_TX_FULL      = 4;
    localparam int unsigned ST_RX_OVR       = 5;
    localparam int unsigned ST_TX_DROP      = 6;
    localparam int unsigned ST_RX_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;
    localparam int unsigned CTRL_FLUSH = 2;

    typedef enum logic [1:0] {
        TxIdle,
        TxStrobe,
        TxWaitLo,
        TxWaitHi
    } tx_state_t;

    typedef enum logic [1:0] {
        RxIdle,
        RxAck,
        RxWaitClr
    } rx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// CPU register bus plus uart handshake signals of the FIFO bridge.
interface uart_fifo_bridge_if;
    logic [1:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [15:0] cpu_rdata;
    logic        irq;
    logic [7:0]  uart_tx_data;
    logic        uart_write;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_new;
    logic        uart_read;

    // CPU and uart side, as seen by whoever drives the bridge
    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_rdata, irq,
        input  uart_tx_data, uart_write, uart_read,
        output uart_tx_ready, uart_rx_data, uart_rx_new
    );

    // The bridge itself
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_rdata, irq,
        output uart_tx_data, uart_write, uart_read,
        input  uart_tx_ready, uart_rx_data, uart_rx_new
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; flush empties it and overrides push/pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    // Count reaches DEPTH only when full, so its MSB is the full flag
    assign empty = (count_q == '0);
    assign full  = count_q[DEPTH_LOG2];
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    // Storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU-side buffering front end for the uart: TX/RX FIFOs, register decode,
// sticky error flags, level irq and the two uart handshake FSMs.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic              clk,
    input logic              rst_n,
    uart_fifo_bridge_if.slave bus
);

    logic [7:0]          tx_dout;
    logic                tx_push;
    logic                tx_pop;
    logic                tx_empty;
    logic                tx_full;
    logic [DEPTH_LOG2:0] tx_count;
    logic [7:0]          rx_dout;
    logic                rx_push;
    logic                rx_pop;
    logic                rx_empty;
    logic                rx_full;
    logic [DEPTH_LOG2:0] rx_count;

    logic        flush_q;
    logic        rx_ie_q;
    logic        tx_ie_q;
    logic        tx_drop_q;
    logic        rx_ovr_q;
    logic        irq_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] rdata_next;
    logic [15:0] status;
    logic [7:0]  tx_data_q;
    logic        uart_write_q;
    logic        uart_read_q;
    tx_state_t   tx_state_q;
    rx_state_t   rx_state_q;

    logic wr_data;
    logic wr_status;
    logic wr_ctrl;
    logic rd_data;
    logic tx_load;
    logic rx_take;

    assign wr_data   = bus.cpu_we && (bus.cpu_addr == REG_DATA);
    assign wr_status = bus.cpu_we && (bus.cpu_addr == REG_STATUS);
    assign wr_ctrl   = bus.cpu_we && (bus.cpu_addr == REG_CTRL);
    assign rd_data   = bus.cpu_re && (bus.cpu_addr == REG_DATA);

    // A flushed head must not be sent, so loading waits out the flush cycle
    assign tx_load = (tx_state_q == TxIdle) && !tx_empty && bus.uart_tx_ready && !flush_q;
    assign rx_take = (rx_state_q == RxIdle) && bus.uart_rx_new;

    assign tx_push = wr_data;
    assign tx_pop  = tx_load;
    assign rx_push = rx_take;
    assign rx_pop  = rd_data;

    uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush_q),
        .din   (bus.cpu_wdata[7:0]),
        .dout  (tx_dout),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush_q),
        .din   (bus.uart_rx_data),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    // STATUS word and read-data selection
    always_comb begin
        status                            = '0;
        status[ST_TX_READY]               = bus.uart_tx_ready;
        status[ST_RX_EMPTY]               = rx_empty;
        status[ST_RX_FULL]                = rx_full;
        status[ST_TX_EMPTY]               = tx_empty;
        status[ST_TX_FULL]                = tx_full;
        status[ST_RX_OVR]                 = rx_ovr_q;
        status[ST_TX_DROP]                = tx_drop_q;
        status[ST_RX_COUNT_LSB +: 8]      = 8'(rx_count);
        case (bus.cpu_addr)
            REG_DATA:   rdata_next = rx_empty ? 16'h0000 : {8'h00, rx_dout};
            REG_STATUS: rdata_next = status;
            REG_CTRL:   rdata_next = {14'b0, tx_ie_q, rx_ie_q};
            default:    rdata_next = 16'h0000;
        endcase
    end

    // Read data register, control bits, sticky flags and irq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            flush_q     <= 1'b0;
            tx_drop_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (bus.cpu_re) cpu_rdata_q <= rdata_next;
            if (wr_ctrl) begin
                rx_ie_q <= bus.cpu_wdata[CTRL_RX_IE];
                tx_ie_q <= bus.cpu_wdata[CTRL_TX_IE];
            end
            flush_q <= wr_ctrl && bus.cpu_wdata[CTRL_FLUSH];
            // A set in the same cycle as a W1C clear keeps the flag
            tx_drop_q <= (tx_drop_q && !(wr_status && bus.cpu_wdata[ST_TX_DROP]))
                         || (wr_data && tx_full && !tx_pop && !flush_q);
            rx_ovr_q  <= (rx_ovr_q && !(wr_status && bus.cpu_wdata[ST_RX_OVR]))
                         || (rx_take && rx_full && !rx_pop && !flush_q);
            irq_q <= (rx_ie_q && !rx_empty) || (tx_ie_q && tx_empty);
        end
    end

    // TX FSM: load head, one-cycle write strobe, then wait for a full ready low/high cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q   <= TxIdle;
            tx_data_q    <= '0;
            uart_write_q <= 1'b0;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_load) begin
                        tx_data_q    <= tx_dout;
                        uart_write_q <= 1'b1;
                        tx_state_q   <= TxStrobe;
                    end
                end
                TxStrobe: begin
                    uart_write_q <= 1'b0;
                    tx_state_q   <= TxWaitLo;
                end
                TxWaitLo: begin
                    if (!bus.uart_tx_ready) tx_state_q <= TxWaitHi;
                end
                TxWaitHi: begin
                    if (bus.uart_tx_ready) tx_state_q <= TxIdle;
                end
            endcase
        end
    end

    // RX FSM: capture once per rx_new, acknowledge, wait for rx_new to drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RxIdle;
            uart_read_q <= 1'b0;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (rx_take) begin
                        uart_read_q <= 1'b1;
                        rx_state_q  <= RxAck;
                    end
                end
                RxAck: begin
                    uart_read_q <= 1'b0;
                    rx_state_q  <= RxWaitClr;
                end
                RxWaitClr: begin
                    if (!bus.uart_rx_new) rx_state_q <= RxIdle;
                end
                default: begin
                    uart_read_q <= 1'b0;
                    rx_state_q  <= RxIdle;
                end
            endcase
        end
    end

    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.irq          = irq_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.uart_write   = uart_write_q;
    assign bus.uart_read    = uart_read_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: uart behavioural model, queue-based reference
// model of the FIFOs/flags, and a read monitor fed by an expected-value queue.
module tb_uart_fifo_bridge;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_bridge_if bus ();

    uart_fifo_bridge #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0]  tx_exp [$];
    logic [7:0]  rx_m [$];
    logic [15:0] rd_exp [$];
    string       rd_name [$];
    bit tx_drop_m = 0, rx_ovr_m = 0, rx_ie_m = 0, tx_ie_m = 0;

    // uart model state
    bit         tx_block = 0;
    int         tx_busy = 0;
    int         tx_edges = 0;
    int         rx_req_cnt = 0, rx_done_cnt = 0, rx_acks = 0, rx_gap = 0;
    logic [7:0] rx_req_byte = 8'h00;
    logic       wr_prev = 1'b0, rd_prev = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [15:0] status_exp();
        logic [15:0] s;
        s = '0;
        s[15:8] = 8'(rx_m.size());
        s[6] = tx_drop_m;
        s[5] = rx_ovr_m;
        s[4] = (tx_exp.size() == DEPTH);
        s[3] = (tx_exp.size() == 0);
        s[2] = (rx_m.size() == DEPTH);
        s[1] = (rx_m.size() == 0);
        s[0] = bus.uart_tx_ready;
        return s;
    endfunction

    // uart model: reacts 1 unit after each falling edge
    initial begin
        bus.uart_tx_ready = 1'b1;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_new   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.uart_write && !wr_prev) begin
                tx_edges++;
                check("tx_edge_ready", {15'b0, (tx_busy == 0) && bus.uart_tx_ready}, 16'd1);
                if (tx_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_stray: got byte %h expected none", bus.uart_tx_data);
                end else begin
                    check("tx_byte", {8'h00, bus.uart_tx_data}, {8'h00, tx_exp.pop_front()});
                end
                tx_busy = $urandom_range(2, 5);
                bus.uart_tx_ready = 1'b0;
            end else if (tx_busy > 0) begin
                tx_busy--;
            end else begin
                bus.uart_tx_ready = !tx_block;
            end
            wr_prev = bus.uart_write;

            if (bus.uart_read && !rd_prev) begin
                bus.uart_rx_new = 1'b0;
                rx_acks++;
                rx_gap = 3;
            end else if (rx_gap > 0) begin
                rx_gap--;
            end else if (rx_req_cnt != rx_done_cnt && !bus.uart_rx_new) begin
                bus.uart_rx_data = rx_req_byte;
                bus.uart_rx_new  = 1'b1;
                rx_done_cnt++;
            end
            rd_prev = bus.uart_read;
        end
    end

    // Read monitor: cpu_rdata is due the cycle after cpu_re
    initial begin
        logic re_s;
        forever begin
            @(posedge clk);
            re_s = bus.cpu_re && rst_n;
            @(negedge clk);
            if (re_s) begin
                if (rd_exp.size() == 0) fail_now("rd_unexpected");
                else check(rd_name.pop_front(), bus.cpu_rdata, rd_exp.pop_front());
            end
        end
    end

    task automatic cpu_write(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.cpu_we    = 1'b1;
        case (addr)
            REG_DATA: begin
                if (tx_exp.size() >= DEPTH) tx_drop_m = 1;
                else tx_exp.push_back(data[7:0]);
            end
            REG_STATUS: begin
                if (data[6]) tx_drop_m = 0;
                if (data[5]) rx_ovr_m = 0;
            end
            REG_CTRL: begin
                rx_ie_m = data[0];
                tx_ie_m = data[1];
                if (data[2]) begin
                    tx_exp.delete();
                    rx_m.delete();
                end
            end
            default: ;
        endcase
        @(negedge clk);
        bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] addr, input string name);
        logic [15:0] e;
        @(negedge clk);
        bus.cpu_addr = addr;
        bus.cpu_re   = 1'b1;
        #2;
        case (addr)
            REG_DATA:   e = (rx_m.size() > 0) ? {8'h00, rx_m.pop_front()} : 16'h0000;
            REG_STATUS: e = status_exp();
            REG_CTRL:   e = {14'b0, tx_ie_m, rx_ie_m};
            default:    e = 16'h0000;
        endcase
        rd_exp.push_back(e);
        rd_name.push_back(name);
        @(negedge clk);
        bus.cpu_re = 1'b0;
    endtask

    task automatic wait_ack(input int a0, input string name);
        int n;
        n = 0;
        while (rx_acks == a0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (rx_acks == a0) fail_now(name);
    endtask

    task automatic deliver(input logic [7:0] b);
        int a0;
        a0 = rx_acks;
        rx_req_byte = b;
        rx_req_cnt++;
        if (rx_m.size() >= DEPTH) rx_ovr_m = 1;
        else rx_m.push_back(b);
        wait_ack(a0, "rx_ack");
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (!(tx_exp.size() == 0 && tx_busy == 0 && bus.uart_tx_ready) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) fail_now("tx_drain");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int edges0;
        int n;
        bus.cpu_addr  = 2'd0;
        bus.cpu_wdata = 16'h0000;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus.cpu_rdata, 16'h0000);
        check("rst_irq", {15'b0, bus.irq}, 16'h0000);
        check("rst_tx_data", {8'h00, bus.uart_tx_data}, 16'h0000);
        check("rst_write", {15'b0, bus.uart_write}, 16'h0000);
        check("rst_read", {15'b0, bus.uart_read}, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cpu_read(REG_CTRL, "rst_ctrl");
        cpu_read(REG_STATUS, "rst_status");

        // Three bytes out through the uart handshake
        cpu_write(REG_DATA, 16'h0041);
        cpu_write(REG_DATA, 16'h0042);
        cpu_write(REG_DATA, 16'h0043);
        wait_tx_idle();
        check("tx_edges3", 16'(tx_edges), 16'd3);
        cpu_read(REG_STATUS, "status_tx_done");

        // Overfill TX while the uart is not ready
        tx_block = 1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 17; i++) cpu_write(REG_DATA, 16'h0060 + 16'(i));
        repeat (2) @(negedge clk);
        cpu_read(REG_STATUS, "status_tx_full");
        cpu_write(REG_STATUS, 16'h0040);
        cpu_read(REG_STATUS, "status_drop_clr");
        tx_block = 0;
        wait_tx_idle();
        check("tx_edges19", 16'(tx_edges), 16'd19);
        cpu_read(REG_STATUS, "status_tx_drained");

        // Two received bytes
        deliver(8'h55);
        deliver(8'hAA);
        repeat (6) @(negedge clk);
        check("rx_acks2", 16'(rx_acks), 16'd2);
        cpu_read(REG_STATUS, "status_rx2");
        cpu_read(REG_DATA, "rd_55");
        cpu_read(REG_DATA, "rd_aa");
        cpu_read(REG_DATA, "rd_empty");

        // Overfill RX
        for (int i = 0; i < 17; i++) deliver(8'($urandom));
        repeat (6) @(negedge clk);
        cpu_read(REG_STATUS, "status_rx_full");
        cpu_write(REG_STATUS, 16'h0020);
        repeat (6) @(negedge clk);
        // Pop and push in the same cycle on a full RX FIFO
        a0 = rx_acks;
        @(negedge clk);
        rx_req_byte = 8'h99;
        rx_req_cnt++;
        bus.cpu_addr = REG_DATA;
        bus.cpu_re   = 1'b1;
        rd_exp.push_back({8'h00, rx_m.pop_front()});
        rd_name.push_back("rd_same_cycle");
        rx_m.push_back(8'h99);
        @(negedge clk);
        bus.cpu_re = 1'b0;
        wait_ack(a0, "rx_ack_same_cycle");
        repeat (4) @(negedge clk);
        cpu_read(REG_STATUS, "status_same_cycle");
        for (int i = 0; i < 16; i++) cpu_read(REG_DATA, "rd_rx_fifo");
        cpu_read(REG_DATA, "rd_rx_after");

        // Interrupt behaviour
        cpu_write(REG_CTRL, 16'h0003);
        repeat (2) @(negedge clk);
        check("irq_tx", {15'b0, bus.irq}, 16'd1);
        cpu_write(REG_CTRL, 16'h0001);
        repeat (2) @(negedge clk);
        check("irq_off", {15'b0, bus.irq}, 16'd0);
        deliver(8'h77);
        repeat (2) @(negedge clk);
        check("irq_rx", {15'b0, bus.irq}, 16'd1);
        cpu_read(REG_DATA, "rd_77");
        check("irq_latency", {15'b0, bus.irq}, 16'd1);
        @(negedge clk);
        check("irq_rx_clr", {15'b0, bus.irq}, 16'd0);

        // Flush with bytes in both FIFOs
        tx_block = 1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) cpu_write(REG_DATA, 16'(8'($urandom)));
        deliver(8'h11);
        deliver(8'h22);
        cpu_write(REG_CTRL, 16'h0005);
        repeat (2) @(negedge clk);
        cpu_read(REG_STATUS, "status_flush");
        cpu_read(REG_CTRL, "ctrl_flush_clear");
        cpu_read(REG_DATA, "rd_after_flush");
        check("irq_after_flush", {15'b0, bus.irq}, 16'd0);
        tx_block = 0;
        wait_tx_idle();

        // Randomized mixed traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: if (tx_exp.size() < 12) cpu_write(REG_DATA, 16'($urandom));
                1: if (rx_m.size() < DEPTH) deliver(8'($urandom));
                2: cpu_read(REG_DATA, "rd_rand");
                default: cpu_read(REG_CTRL, "ctrl_rand");
            endcase
        end
        wait_tx_idle();
        cpu_read(REG_STATUS, "status_rand");

        // Reset during the write strobe
        cpu_write(REG_CTRL, 16'h0002);
        cpu_read(REG_CTRL, "ctrl_tx_ie");
        cpu_write(REG_DATA, 16'h00C3);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            if (bus.uart_write) break;
            n++;
        end
        if (n >= 30) fail_now("strobe_seen");
        rst_n = 1'b0;
        #1;
        tx_exp.delete();
        rx_m.delete();
        tx_drop_m = 0;
        rx_ovr_m  = 0;
        rx_ie_m   = 0;
        tx_ie_m   = 0;
        check("arst_rdata", bus.cpu_rdata, 16'h0000);
        check("arst_irq", {15'b0, bus.irq}, 16'h0000);
        check("arst_tx_data", {8'h00, bus.uart_tx_data}, 16'h0000);
        check("arst_write", {15'b0, bus.uart_write}, 16'h0000);
        check("arst_read", {15'b0, bus.uart_read}, 16'h0000);
        edges0 = tx_edges;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_stray_write", 16'(tx_edges), 16'(edges0));
        cpu_read(REG_CTRL, "ctrl_after_arst");
        cpu_write(REG_DATA, 16'h005A);
        wait_tx_idle();
        check("tx_after_arst", 16'(tx_edges), 16'(edges0 + 1));
        check("rx_ack_count", 16'(rx_acks), 16'(rx_done_cnt));
        repeat (3) @(negedge clk);
        check("rd_queue_empty", 16'(rd_exp.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
